// File: rtl/xm_wb_ram.sv
// xm_wb_ram: Wishbone classic-cycle slave word memory.
//
// Purpose: 2^DEPTH_LOG2 words of WORD-bit storage with per-byte write lanes
// and a programmable number of wait states (0..15) before the acknowledge.
//
// Ports:
//   clk_i  - clock, all state changes on the rising edge
//   arst_i - asynchronous active-low reset
//   cyc_i  - bus cycle valid
//   stb_i  - strobe
//   we_i   - 1 = write, 0 = read
//   sel_i  - byte-lane select, bit n covers dat[8n+7:8n]
//   adr_i  - word address; only the low DEPTH_LOG2 bits are decoded
//   dat_i  - write data
//   ack_o  - one-cycle transfer acknowledge
//   dat_o  - read data, held between reads
//
// Handshake: a request is taken when cyc_i & stb_i are both high at a rising
// edge while idle. Address, direction, lanes and write data are captured on
// that edge, so the master may change them afterwards. ack_o is high for
// exactly one cycle, WAIT+1 cycles after the request edge. The memory write
// or read-data capture happens on the edge that enters the acknowledge state.
// Dropping cyc_i while wait states are still being counted abandons the
// transfer with no side effect; once acknowledging, the transfer is complete.
module xm_wb_ram #(
  parameter int WORD       = 16,
  parameter int ADR_W      = 15,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 1
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [WORD/8-1:0] sel_i,
  input  logic [ADR_W-1:0]  adr_i,
  input  logic [WORD-1:0]   dat_i,
  output logic              ack_o,
  output logic [WORD-1:0]   dat_o
);

  localparam int SEL_W = WORD / 8;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_next;

  logic [DEPTH_LOG2-1:0] r_adr;
  logic                  r_we;
  logic [SEL_W-1:0]      r_sel;
  logic [WORD-1:0]       r_wdat;
  logic [WORD-1:0]       r_rdata;

  logic [WORD-1:0]       r_mem [DEPTH];

  logic                  w_req;
  logic                  w_latch;
  logic                  w_commit;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_we;
  logic [SEL_W-1:0]      w_sel;
  logic [WORD-1:0]       w_wdat;

  // Upper address bits are deliberately ignored (memory aliases).
  logic                  w_unused_adr;
  assign w_unused_adr = ^adr_i;

  assign w_req = cyc_i & stb_i;

  // Next-state / control decode.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_latch    = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_latch    = 1'b1;
          w_cnt_next = 4'(WAIT);
          if (WAIT == 0) begin
            w_next   = S_ACK;
            w_commit = 1'b1;
          end else begin
            w_next   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          // Master abandoned the cycle: no commit.
          w_next     = S_IDLE;
          w_cnt_next = 4'd0;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_next   = S_ACK;
            w_commit = 1'b1;
          end
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // With zero wait states the commit edge is also the request edge, so the
  // live bus values are used instead of the not-yet-loaded latches.
  assign w_idx  = w_latch ? adr_i[DEPTH_LOG2-1:0] : r_adr;
  assign w_we   = w_latch ? we_i  : r_we;
  assign w_sel  = w_latch ? sel_i : r_sel;
  assign w_wdat = w_latch ? dat_i : r_wdat;

  // Gate with reset so a request seen while reset is held cannot write.
  assign w_mem_we = w_commit & w_we & arst_i;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_adr  <= adr_i[DEPTH_LOG2-1:0];
        r_we   <= we_i;
        r_sel  <= sel_i;
        r_wdat <= dat_i;
      end
      if (w_commit && !w_we) begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (w_sel[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
        end
      end
    end
  end

  assign ack_o = (r_state == S_ACK);
  assign dat_o = r_rdata;

endmodule

// File: tb/tb_xm_wb_ram.sv
// tb_xm_wb_ram: directed bench for xm_wb_ram.
// Three instances with WAIT = 1, 3 and 0 share one clock; each has its own
// reset and bus signals, selected by index in the driver task.
module tb_xm_wb_ram;

  localparam int W0 = 1;
  localparam int W1 = 3;
  localparam int W2 = 0;

  // Clock / reset / bus signals
  logic        clk;
  logic        rst_n [3];
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [1:0]  sel   [3];
  logic [14:0] adr   [3];
  logic [15:0] dat_w [3];
  logic        ack   [3];
  logic [15:0] dat_r [3];

  int n_checks;
  int n_errors;

  logic [15:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [14:0] adr;
    logic [15:0] dat;
    logic [15:0] exp_dat;  // dat_o expected after the transfer
  } vec_t;

  vec_t tbl [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  xm_wb_ram #(.WORD(16), .ADR_W(15), .DEPTH_LOG2(10), .WAIT(W0)) u_w1 (
    .clk_i(clk), .arst_i(rst_n[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
    .we_i(we[0]), .sel_i(sel[0]), .adr_i(adr[0]), .dat_i(dat_w[0]),
    .ack_o(ack[0]), .dat_o(dat_r[0])
  );

  xm_wb_ram #(.WORD(16), .ADR_W(15), .DEPTH_LOG2(10), .WAIT(W1)) u_w3 (
    .clk_i(clk), .arst_i(rst_n[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
    .we_i(we[1]), .sel_i(sel[1]), .adr_i(adr[1]), .dat_i(dat_w[1]),
    .ack_o(ack[1]), .dat_o(dat_r[1])
  );

  xm_wb_ram #(.WORD(16), .ADR_W(15), .DEPTH_LOG2(10), .WAIT(W2)) u_w0 (
    .clk_i(clk), .arst_i(rst_n[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
    .we_i(we[2]), .sel_i(sel[2]), .adr_i(adr[2]), .dat_i(dat_w[2]),
    .ack_o(ack[2]), .dat_o(dat_r[2])
  );

  function automatic int wait_of(input int k);
    case (k)
      0:       return W0;
      1:       return W1;
      default: return W2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete transfer. Bus inputs are scrambled right after the request
  // edge; ack latency and single-cycle ack are checked here.
  task automatic xfer(input int k, input logic w, input logic [1:0] s,
                      input logic [14:0] a, input logic [15:0] d,
                      output logic [15:0] rd);
    int lat;
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1;
    we[k] = w; sel[k] = s; adr[k] = a; dat_w[k] = d;
    @(posedge clk); #1;
    we[k] = ~w; sel[k] = ~s; adr[k] = a ^ 15'h0155; dat_w[k] = ~d;
    lat = 1;
    while (!ack[k] && lat <= 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ack latency", 32'(lat), 32'(wait_of(k) + 1));
    rd = dat_r[k];
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(posedge clk); #1;
    chk("ack single pulse", 32'(ack[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic        seen;
    int          nreq;

    n_checks = 0;
    n_errors = 0;

    tbl[0]  = '{1'b1, 2'b11, 15'h0010, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 2'b11, 15'h0010, 16'h0000, 16'hBEEF};
    tbl[2]  = '{1'b1, 2'b11, 15'h0020, 16'h1234, 16'hBEEF};
    tbl[3]  = '{1'b1, 2'b10, 15'h0020, 16'hAB00, 16'hBEEF};
    tbl[4]  = '{1'b0, 2'b01, 15'h0020, 16'h0000, 16'hAB34};
    tbl[5]  = '{1'b1, 2'b01, 15'h0020, 16'h00CD, 16'hAB34};
    tbl[6]  = '{1'b0, 2'b00, 15'h0020, 16'h0000, 16'hABCD};
    tbl[7]  = '{1'b1, 2'b00, 15'h0020, 16'hFFFF, 16'hABCD};
    tbl[8]  = '{1'b0, 2'b11, 15'h0020, 16'h0000, 16'hABCD};
    tbl[9]  = '{1'b1, 2'b11, 15'h0005, 16'h0F0F, 16'hABCD};
    tbl[10] = '{1'b0, 2'b11, 15'h0405, 16'h0000, 16'h0F0F};
    tbl[11] = '{1'b0, 2'b10, 15'h7C10, 16'h0000, 16'hBEEF};

    // Reset
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      sel[k] = 2'b00; adr[k] = '0; dat_w[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset ack", 32'(ack[k]), 32'd0);
      chk("reset dat_o", 32'(dat_r[k]), 32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    // Table: WAIT=1 latency, byte lanes, sel=00, aliasing
    for (int i = 0; i < 12; i++) begin
      xfer(0, tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, rd);
      chk($sformatf("vec%0d dat_o", i), 32'(rd), 32'(tbl[i].exp_dat));
    end

    // WAIT=3: establish prior value
    xfer(1, 1'b1, 2'b11, 15'h0030, 16'h7777, rd);
    chk("w3 write keeps dat_o", 32'(rd), 32'h0);
    xfer(1, 1'b0, 2'b11, 15'h0030, 16'h0000, rd);
    chk("w3 read prior", 32'(rd), 32'h7777);

    // Abort: drop cyc one cycle after the request edge
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11;
    adr[1] = 15'h0030; dat_w[1] = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack[1]) seen = 1'b1;
    end
    chk("abort no ack", 32'(seen), 32'd0);
    chk("abort dat_o held", 32'(dat_r[1]), 32'h7777);
    xfer(1, 1'b0, 2'b11, 15'h0030, 16'h0000, rd);
    chk("abort mem unchanged", 32'(rd), 32'h7777);

    // Reset mid-transfer while counting wait states
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11;
    adr[1] = 15'h0030; dat_w[1] = 16'h9999;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n[1] = 1'b0;
    #1;
    chk("rst mid ack", 32'(ack[1]), 32'd0);
    chk("rst mid dat_o", 32'(dat_r[1]), 32'd0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack[1]) seen = 1'b1;
    end
    chk("rst hold no ack", 32'(seen), 32'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    xfer(1, 1'b0, 2'b11, 15'h0030, 16'h0000, rd);
    chk("rst mem unchanged", 32'(rd), 32'h7777);

    // WAIT=0: preload then back-to-back reads with cyc/stb held
    for (int i = 0; i < 4; i++) begin
      xfer(2, 1'b1, 2'b11, 15'(15'h0100 + i), 16'(16'h1111 * (i + 1)), rd);
    end
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 2'b01;
    adr[2] = 15'h0100;
    nreq = 0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b ack cyc%0d", e), 32'(ack[2]), 32'((e % 2) == 0));
      if (ack[2]) begin
        if (exp_q.size() > 0) begin
          chk($sformatf("b2b dat%0d", nreq), 32'(dat_r[2]), 32'(exp_q.pop_front()));
        end
        nreq++;
        if (nreq < 4) begin
          adr[2] = 15'(15'h0100 + nreq);
        end else begin
          cyc[2] = 1'b0; stb[2] = 1'b0;
        end
      end
    end
    chk("b2b queue drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
